// File: rtl/pci_arbiter.sv
// ---------------------------------------------------------------------------
// pci_arbiter
//   Four-master PCI bus arbiter with round-robin priority, bus parking on the
//   last owner, a one-clock dead cycle when the grant moves on an idle bus,
//   and a watchdog that revokes a grant from a master that never starts.
//
// Ports
//   CLK      in   PCI clock, all state updates on the rising edge
//   RESET    in   synchronous reset, active-low
//   REQ[3:0] in   per-master request, active-low (bit n = master n)
//   GNT[3:0] out  per-master grant, active-low, registered
//   FRAME    in   PCI FRAME#, active-low
//   IRDY     in   PCI IRDY#, active-low
//   OWNER    out  index of the current or last granted master, registered
//   TIMEOUT  out  one-clock pulse when the watchdog revokes a grant
// ---------------------------------------------------------------------------
module pci_arbiter #(
    parameter int WDOG = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] REQ,
    output logic [3:0] GNT,
    input  logic       FRAME,
    input  logic       IRDY,
    output logic [1:0] OWNER,
    output logic       TIMEOUT
);

    typedef enum logic {
        ST_GRANT = 1'b0,
        ST_DEAD  = 1'b1
    } state_t;

    localparam logic [7:0] WDOG_LIMIT = 8'(WDOG);

    state_t     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] latch_q, latch_d;
    logic       started_q, started_d;
    logic [7:0] wdog_cnt_q, wdog_cnt_d;
    logic       timeout_q, timeout_d;
    logic       frame_prev_q, frame_prev_d;

    logic       bus_idle;
    logic       frame_fall;
    logic       expired;
    logic       releasable;
    logic [2:0] pick;
    logic       have_winner;
    logic [1:0] winner;

    // Round-robin search. Walking from the farthest candidate (the owner
    // itself) back to the nearest one leaves the nearest requester in pick.
    // Result is {valid, index}.
    function automatic logic [2:0] rr_pick(input logic [3:0] req_n,
                                           input logic [1:0] own);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = own + k[1:0];
            if (!req_n[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign bus_idle    = FRAME & IRDY;
    assign frame_fall  = frame_prev_q & ~FRAME;
    assign expired     = (wdog_cnt_q == WDOG_LIMIT);
    assign releasable  = REQ[owner_q] | started_q | expired;
    assign pick        = rr_pick(REQ, owner_q);
    assign have_winner = pick[2];
    assign winner      = pick[1:0];

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        owner_d      = owner_q;
        latch_d      = latch_q;
        started_d    = started_q;
        wdog_cnt_d   = wdog_cnt_q;
        timeout_d    = 1'b0;
        frame_prev_d = FRAME;

        unique case (state_q)
            ST_DEAD: begin
                // The latched winner gets the bus regardless of its current REQ.
                state_d    = ST_GRANT;
                gnt_d      = ~(4'b0001 << latch_q);
                owner_d    = latch_q;
                started_d  = 1'b0;
                wdog_cnt_d = 8'd0;
            end
            ST_GRANT: begin
                if (have_winner && (winner != owner_q) && releasable) begin
                    timeout_d  = expired;
                    started_d  = 1'b0;
                    wdog_cnt_d = 8'd0;
                    if (bus_idle) begin
                        // Idle bus: insert a dead cycle so two masters never
                        // see GNT on adjacent edges with nobody driving.
                        state_d = ST_DEAD;
                        gnt_d   = 4'b1111;
                        latch_d = winner;
                    end else begin
                        gnt_d   = ~(4'b0001 << winner);
                        owner_d = winner;
                    end
                end else begin
                    if (frame_fall) begin
                        started_d = 1'b1;
                    end
                    // Count idle clocks while the owner sits on its grant
                    // without starting; saturates at the limit.
                    if (bus_idle && !started_q && !REQ[owner_q] && !expired) begin
                        wdog_cnt_d = wdog_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_GRANT;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q      <= ST_GRANT;
            gnt_q        <= 4'b1110;
            owner_q      <= 2'd0;
            latch_q      <= 2'd0;
            started_q    <= 1'b0;
            wdog_cnt_q   <= 8'd0;
            timeout_q    <= 1'b0;
            frame_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            owner_q      <= owner_d;
            latch_q      <= latch_d;
            started_q    <= started_d;
            wdog_cnt_q   <= wdog_cnt_d;
            timeout_q    <= timeout_d;
            frame_prev_q <= frame_prev_d;
        end
    end

    assign GNT     = gnt_q;
    assign OWNER   = owner_q;
    assign TIMEOUT = timeout_q;

endmodule

// File: doc/pci_arbiter.md
PCI_ARBITER -- requirements
Module: pci_arbiter

Interface
REQ-001 Parameter WDOG, default 16, means the number of idle-bus clocks a granted master may hold GNT# without starting a transaction; legal range 2..255.
REQ-002 Port CLK, input, 1 bit: PCI clock; all state updates on the rising edge.
REQ-003 Port RESET, input, 1 bit: reset that is synchronous and active-low.
REQ-004 Port REQ, input, 4 bits: per-master bus request, active-low; bit n is master n.
REQ-005 Port GNT, output, 4 bits: per-master grant, active-low, registered.
REQ-006 Port FRAME, input, 1 bit: PCI FRAME#, active-low, sampled.
REQ-007 Port IRDY, input, 1 bit: PCI IRDY#, active-low, sampled.
REQ-008 Port OWNER, output, 2 bits: index of the current or last granted master, registered.
REQ-009 Port TIMEOUT, output, 1 bit: one-clock active-high pulse when the watchdog revokes a grant.

Function
REQ-010 The bus is idle in a cycle when FRAME==1 and IRDY==1 are both sampled at that edge; otherwise it is busy.
REQ-011 The FSM has two states, GRANT (exactly one GNT bit low, the OWNER bit) and DEAD (GNT==4'b1111).
REQ-012 At most one GNT bit is ever 0 in any cycle.
REQ-013 Round-robin winner: the first asserted REQ bit searching OWNER+1, OWNER+2, OWNER+3, OWNER (mod 4); no REQ asserted means no winner.
REQ-014 In GRANT with no winner, or winner==OWNER, GNT and OWNER hold (bus parking on the last owner).
REQ-015 The owner is releasable when REQ[OWNER]==1, or a falling FRAME (1 then 0) has been sampled since the grant was issued, or the watchdog has expired.
REQ-016 In GRANT with winner!=OWNER and the owner releasable: if the bus is busy, GNT moves directly to the winner on the next edge and OWNER updates.
REQ-017 In the same case with the bus idle, the next state is DEAD for exactly one clock, the winner is latched, then GRANT to the latched winner follows.
REQ-018 In DEAD, the latched winner is granted on the following edge even if its REQ has deasserted; OWNER updates on entry to GRANT.
REQ-019 In GRANT with winner!=OWNER and the owner not releasable, GNT holds.
REQ-020 The started flag clears on every new grant and sets on a sampled falling FRAME while in GRANT.
REQ-021 The 8-bit watchdog counter clears on every new grant and increments each GRANT cycle with bus idle, started==0 and REQ[OWNER]==0.
REQ-022 When the counter reaches WDOG, the owner becomes releasable and the counter saturates.
REQ-023 TIMEOUT pulses high for one clock on the edge where a watchdog-expired owner loses GNT.
REQ-024 Grant latency from an idle bus with a releasable owner: REQ sampled at edge t gives DEAD at t+1 and GNT low at t+2.

Reset
REQ-025 RESET==0 sampled at an edge sets GNT=4'b1110, OWNER=0, state GRANT, started=0, counter=0, TIMEOUT=0, overriding all other inputs.
REQ-026 Reset asserted mid-transaction or in DEAD returns to the REQ-025 values on the next edge; FRAME and IRDY are ignored during reset.
REQ-027 After RESET returns to 1, arbitration resumes from OWNER=0 on the following edge.

Verification
REQ-028 Scenario: after reset, REQ=1111 for 10 clocks -> GNT stays 1110, OWNER=0, TIMEOUT=0.
REQ-029 Scenario: idle bus, REQ=1101 sampled at edge t -> GNT=1111 at t+1, GNT=1101 and OWNER=1 at t+2.
REQ-030 Scenario: REQ=0000 with masters taking turns, each asserting FRAME for 3 clocks after its grant -> grant order 1,2,3,0,1 with no GNT overlap.
REQ-031 Scenario: owner 2 mid-transaction (FRAME=0) while REQ[3] asserts -> GNT switches directly from 1011 to 0111 with no DEAD cycle.
REQ-032 Scenario: WDOG=16, owner 1 holds REQ low and never asserts FRAME on an idle bus while REQ[2] is low -> after 16 idle clocks TIMEOUT pulses once, then DEAD, then GNT=1011.
REQ-033 Scenario: RESET=0 during DEAD or during an active transaction -> next edge GNT=1110 and OWNER=0.
